instr_sequencer: RTL
====================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 run  input  1  level enable; high permits instruction issue.
REQ-005 imem_req  output  1  instruction fetch request.
REQ-006 imem_addr  output  32  fetch address (equals pc).
REQ-007 imem_ack  input  1  fetch completion; imem_rdata valid in the same cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 pc  output  32  current program counter.
REQ-010 imm12  output  12  I-type immediate, instr[31:20].
REQ-011 alu_imm  output  1  ALU second operand is the immediate.
REQ-012 alu_funct3 / alu_funct7  output  3 / 7  instr[14:12] / instr[31:25].
REQ-013 rf_we  output  1  register-file write strobe.
REQ-014 instret  output  32  retired-instruction counter.
REQ-015 halted  output  1  sequencer in HALT state.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, DECODE, EXEC, WB and HALT.
REQ-017 IDLE: if run=1, go to FETCH next cycle; otherwise stay in IDLE.
REQ-018 FETCH: imem_req=1 and imem_addr=pc, both held stable until imem_ack=1.
REQ-019 On imem_ack in FETCH, latch imem_rdata into the instruction register and go to DECODE.
REQ-020 An ack in the first FETCH cycle is legal (zero-wait).
REQ-021 imem_ack outside FETCH SHALL be ignored.
REQ-022 DECODE (1 cycle): register the control fields from the latched instruction.
- opcode 7'b0010011 (OP-IMM): alu_imm=1, imm12=instr[31:20], write enabled.
- opcode 7'b0110011 (OP): alu_imm=0, imm12 held, write enabled.
- Any other opcode: illegal (see REQ-032).
REQ-023 alu_funct3 and alu_funct7 SHALL be loaded in DECODE and held stable through WB.
REQ-024 EXEC: one cycle; outputs are stable and the ALU result settles.
REQ-025 WB: rf_we=1 for exactly this one cycle, for legal instructions only.
REQ-026 WB: pc <= pc+4, wrapping modulo 2^32; instret <= instret+1, wrapping modulo 2^32.
REQ-027 WB exit: to FETCH if run=1, otherwise to IDLE.
REQ-028 Latency: ack at cycle N gives DECODE at N+1, EXEC at N+2, WB at N+3, and the next imem_req at N+4.
REQ-029 run deasserted in FETCH, DECODE or EXEC: the instruction SHALL complete (including its ack wait), then enter IDLE.
REQ-030 rf_we SHALL be 0 in all states other than WB.
REQ-031 HALT is sticky until reset; halted=1 only in HALT; imem_req=0 and rf_we=0 in HALT.

Reset
REQ-032 While rst_n=0, outputs SHALL take their reset values immediately, independent of clk:
- state=IDLE, pc=RESET_PC, instret=0
- imem_req=0, rf_we=0, halted=0
- imm12=0, alu_imm=0, alu_funct3=0, alu_funct7=0, instruction register=0
REQ-033 Reset asserted mid-fetch or mid-instruction SHALL abort it; no rf_we pulse and no pc or instret update.

Configuration
REQ-034 Macro SEQ_ILLEGAL_TRAP_EN SHALL control the handling of illegal opcodes.
- Defined: an illegal opcode goes DECODE -> HALT; pc and instret SHALL NOT advance.
- Not defined: an illegal opcode executes as a NOP; it passes through EXEC and WB with rf_we=0; pc advances by 4 and instret increments.

Verification
REQ-035 Reset with run=1, imem_ack tied to 1, imem_rdata=32'h00500093 (addi x1,x0,5):
- imem_req at 32'h0, 32'h4, 32'h8, ...
- one rf_we pulse every 4 cycles
- imm12=12'h005, alu_imm=1
- instret=3 after the third WB
REQ-036 imem_ack delayed 3 cycles, imem_rdata=32'h002081B3 (add):
- imem_addr stable during the wait
- alu_imm=0, alu_funct3=0, alu_funct7=0
- rf_we exactly 3 cycles after ack
REQ-037 run dropped during EXEC: WB completes, pc advances by 4, then IDLE with imem_req=0; reassert run: fetch resumes at the new pc.
REQ-038 imem_rdata=32'h00000063 (branch opcode):
- with SEQ_ILLEGAL_TRAP_EN: halted=1, pc unchanged, no rf_we
- without it: no rf_we, pc+4, instret+1
REQ-039 RESET_PC=32'hFFFF_FFFC, one legal instruction: pc wraps to 32'h0; rst_n pulsed low mid-FETCH: pc=RESET_PC and imem_req=0 immediately.

Source files
------------

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/execute/writeback sequencer for a
// small RV32 integer subset (OP-IMM and OP). Each instruction walks
// FETCH -> DECODE -> EXEC -> WB; HALT is a sticky trap state.
// Optional build macro SEQ_ILLEGAL_TRAP_EN: when defined, an illegal opcode
// traps to HALT from DECODE; when undefined, it retires as a NOP.
module instr_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [11:0] imm12,
    output logic        alu_imm,
    output logic [2:0]  alu_funct3,
    output logic [6:0]  alu_funct7,
    output logic        rf_we,
    output logic [31:0] instret,
    output logic        halted
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] DECODE = 3'd2;
    localparam logic [2:0] EXEC   = 3'd3;
    localparam logic [2:0] WB     = 3'd4;
    localparam logic [2:0] HALT   = 3'd5;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [2:0]  state_q,   state_d;
    logic [31:0] pc_q,      pc_d;
    logic [31:0] instret_q, instret_d;
    logic [31:0] instr_q,   instr_d;
    logic [11:0] imm12_q,   imm12_d;
    logic        alu_imm_q, alu_imm_d;
    logic [2:0]  funct3_q,  funct3_d;
    logic [6:0]  funct7_q,  funct7_d;
    logic        legal_q,   legal_d;

    logic        is_op_imm;
    logic        is_op;
    logic        instr_unused;

    assign is_op_imm = (instr_q[6:0] == OPC_OP_IMM);
    assign is_op     = (instr_q[6:0] == OPC_OP);

    // Register-source and destination fields are decoded elsewhere in the core.
    assign instr_unused = ^{instr_q[19:15], instr_q[11:7]};

    // Next-state logic: sequencing, instruction capture, decode and retirement.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instret_d = instret_q;
        instr_d   = instr_q;
        imm12_d   = imm12_q;
        alu_imm_d = alu_imm_q;
        funct3_d  = funct3_q;
        funct7_d  = funct7_q;
        legal_d   = legal_q;
        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                funct3_d = instr_q[14:12];
                funct7_d = instr_q[31:25];
                legal_d  = 1'b0;
                state_d  = EXEC;
                if (is_op_imm) begin
                    alu_imm_d = 1'b1;
                    imm12_d   = instr_q[31:20];
                    legal_d   = 1'b1;
                end else if (is_op) begin
                    alu_imm_d = 1'b0;
                    legal_d   = 1'b1;
                end else begin
`ifdef SEQ_ILLEGAL_TRAP_EN
                    state_d = HALT;
`else
                    state_d = EXEC;
`endif
                end
            end
            EXEC: begin
                state_d = WB;
            end
            WB: begin
                pc_d      = pc_q + 32'd4;
                instret_d = instret_q + 32'd1;
                state_d   = run ? FETCH : IDLE;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            instret_q <= 32'd0;
            instr_q   <= 32'd0;
            imm12_q   <= 12'd0;
            alu_imm_q <= 1'b0;
            funct3_q  <= 3'd0;
            funct7_q  <= 7'd0;
            legal_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instret_q <= instret_d;
            instr_q   <= instr_d;
            imm12_q   <= imm12_d;
            alu_imm_q <= alu_imm_d;
            funct3_q  <= funct3_d;
            funct7_q  <= funct7_d;
            legal_q   <= legal_d;
        end
    end

    assign imem_req   = (state_q == FETCH);
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign instret    = instret_q;
    assign imm12      = imm12_q;
    assign alu_imm    = alu_imm_q;
    assign alu_funct3 = funct3_q;
    assign alu_funct7 = funct7_q;
    assign rf_we      = (state_q == WB) && legal_q;
    assign halted     = (state_q == HALT);

endmodule
